// File: rtl/mem_access_pkg.sv
// Shared definitions for the data memory access unit.
// Contents:
//   - FUNC3 load/store size/sign encodings
//   - state_t : access FSM states (IDLE / ACCESS / DONE)
//   - FAULT_CODE constants
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Word-wide handshaked data memory bus.
// Handshake: the master raises MEM_REQ with MEM_WE/MEM_ADDR/MEM_BYTE_EN/
// MEM_WDATA and holds all of them stable until the slave returns a
// single-cycle MEM_ACK; MEM_RDATA is only meaningful in the MEM_ACK cycle.
// Modports:
//   master : access unit side (drives request, samples ack/rdata)
//   slave  : memory side (samples request, drives ack/rdata)
interface data_mem_access_unit_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [29:0] MEM_ADDR;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BYTE_EN, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BYTE_EN, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/load_store_align.sv
// Purely combinational lane logic for the data memory access unit.
// Request side (from the pipeline, evaluated in IDLE):
//   is_load_i, func3_i, addr_lo_i, wdata_i -> byte_en_o, wdata_o, fault_code_o
// Response side (from the latched request and memory word):
//   ld_func3_i, ld_offset_i, rdata_i -> ld_data_o (extracted and extended)
module load_store_align
  import mem_access_pkg::*;
(
  input  logic        is_load_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  fault_code_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic       illegal;
  logic       misaligned;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  // Store lane formatting; loads always fetch the whole word.
  always_comb begin
    byte_en_o = 4'b1111;
    wdata_o   = wdata_i;
    if (!is_load_i) begin
      case (func3_i[1:0])
        2'b00: begin
          byte_en_o = 4'b0001 << addr_lo_i;
          wdata_o   = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o   = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Illegal encoding outranks misalignment.
  always_comb begin
    if (is_load_i)
      illegal = !(func3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else
      illegal = !(func3_i inside {F3_B, F3_H, F3_W});
    misaligned = ((func3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                 ((func3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    if (illegal)
      fault_code_o = FC_ILLEGAL;
    else if (misaligned)
      fault_code_o = FC_MISALIGN;
    else
      fault_code_o = FC_NONE;
  end

  // Load extraction and extension.
  always_comb begin
    case (ld_offset_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_func3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store responder. Takes MEM_READ/MEM_WRITE strobes from the
// EX/MEM register, runs one transaction at a time on the data memory bus,
// stalls the pipeline through BUSYWAIT and reports faults in DONE.
// Ports:
//   CLK, RESET (async, active-low)
//   MEM_READ, MEM_WRITE, FUNC3, ADDRESS, WRITE_DATA : request from pipeline
//   READ_DATA  : registered, extended load result
//   BUSYWAIT   : pipeline stall
//   FAULT, FAULT_CODE : one-cycle fault report in DONE
//   mem        : memory bus (master side)
//   state_o    : current FSM state, for observation
module data_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          MEM_READ,
  input  logic                          MEM_WRITE,
  input  logic [2:0]                    FUNC3,
  input  logic [31:0]                   ADDRESS,
  input  logic [31:0]                   WRITE_DATA,
  output logic [31:0]                   READ_DATA,
  output logic                          BUSYWAIT,
  output logic                          FAULT,
  output logic [1:0]                    FAULT_CODE,
  data_mem_access_unit_if.master        mem,
  output state_t                        state_o
);

  // Counter value in the last ACCESS cycle allowed before timing out.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  fcode_q, fcode_d;

  logic        req_is_load;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [1:0]  chk_code;
  logic [31:0] ld_data;

  // A simultaneous load and store resolves to the load.
  assign req_is_load = MEM_READ;

  load_store_align u_align (
    .is_load_i    (req_is_load),
    .func3_i      (FUNC3),
    .addr_lo_i    (ADDRESS[1:0]),
    .wdata_i      (WRITE_DATA),
    .byte_en_o    (fmt_be),
    .wdata_o      (fmt_wdata),
    .fault_code_o (chk_code),
    .ld_func3_i   (f3_q),
    .ld_offset_i  (off_q),
    .rdata_i      (mem.MEM_RDATA),
    .ld_data_o    (ld_data)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      fcode_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    fault_d  = 1'b0;
    fcode_d  = FC_NONE;
    BUSYWAIT = 1'b0;
    case (state_q)
      IDLE: begin
        BUSYWAIT = MEM_READ | MEM_WRITE;
        if (MEM_READ || MEM_WRITE) begin
          if (chk_code != FC_NONE) begin
            fault_d = 1'b1;
            fcode_d = chk_code;
            state_d = DONE;
          end else begin
            we_d    = !req_is_load;
            addr_d  = ADDRESS[31:2];
            be_d    = fmt_be;
            wdata_d = fmt_wdata;
            f3_d    = FUNC3;
            off_d   = ADDRESS[1:0];
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (mem.MEM_ACK) begin
          if (!we_q) rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          fault_d = 1'b1;
          fcode_d = FC_TIMEOUT;
          state_d = DONE;
        end
      end
      DONE: begin
        // Strobes present here belong to the next instruction; they are
        // picked up in the following IDLE cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.MEM_REQ     = (state_q == ACCESS);
  assign mem.MEM_WE      = we_q;
  assign mem.MEM_ADDR    = addr_q;
  assign mem.MEM_BYTE_EN = be_q;
  assign mem.MEM_WDATA   = wdata_q;
  assign READ_DATA       = rdata_q;
  assign FAULT           = fault_q;
  assign FAULT_CODE      = fcode_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;
  import mem_access_pkg::*;

  localparam int MAXW = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic        MEM_READ, MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS, WRITE_DATA, READ_DATA;
  logic        BUSYWAIT, FAULT;
  logic [1:0]  FAULT_CODE;
  state_t      state_o;

  data_mem_access_unit_if mem_if ();

  data_mem_access_unit #(.MAX_WAIT(MAXW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .FUNC3      (FUNC3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .mem        (mem_if),
    .state_o    (state_o)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd = '0;

  // Request to present during DONE (back-to-back case).
  bit          nx_valid = 0;
  bit          nx_rd, nx_wr;
  logic [2:0]  nx_f3;
  logic [31:0] nx_addr, nx_wd;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] model_code(input bit ld, input logic [2:0] f3,
                                            input logic [1:0] a);
    bit legal;
    if (ld) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 2'b10;
    if ((int'(a) % acc_size(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [1:0] a,
                                      input logic [31:0] d, output logic [3:0] be,
                                      output logic [31:0] w);
    int sz;
    int ai;
    sz = acc_size(f3);
    ai = int'(a);
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= ai) && (i < ai + sz);
      w[8*i +: 8] = d[8*(i % sz) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    int          v;
    s = rd >> (8 * int'(a));
    b = s[7:0];
    h = s[15:0];
    if (acc_size(f3) == 1) begin
      if (f3[2]) return {24'h0, b};
      v = $signed(b);
      return v;
    end
    if (acc_size(f3) == 2) begin
      if (f3[2]) return {16'h0, h};
      v = $signed(h);
      return v;
    end
    return rd;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    MEM_READ = 0; MEM_WRITE = 0; FUNC3 = '0; ADDRESS = '0; WRITE_DATA = '0;
  endtask

  // One full transaction starting in an IDLE cycle (called just after a
  // negedge). ack_dly: ACCESS cycle index in which MEM_ACK is returned,
  // negative or >= MAXW for no ack.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_dly, input logic [31:0] rdata);
    bit          ld;
    bit          acked;
    logic [1:0]  code;
    logic [1:0]  exp_code;
    logic [3:0]  be;
    logic [31:0] wexp;
    int          busy_n;
    int          exp_busy;
    ld    = rd;
    acked = 0;
    code  = model_code(ld, f3, addr[1:0]);
    model_store(f3, addr[1:0], wd, be, wexp);
    if (ld) be = 4'b1111;

    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = addr; WRITE_DATA = wd;
    #1;
    n_vec++;
    if ({BUSYWAIT, mem_if.MEM_REQ} !== 2'b10) begin
      n_err++;
      $display("FAIL t0_busy_req: got %b exp 10", {BUSYWAIT, mem_if.MEM_REQ});
    end
    busy_n = 1;

    if (code == 2'b00) begin
      for (int k = 0; k < MAXW; k++) begin
        @(negedge CLK);
        n_vec++;
        if ({mem_if.MEM_REQ, BUSYWAIT, mem_if.MEM_WE, mem_if.MEM_ADDR, mem_if.MEM_BYTE_EN}
            !== {1'b1, 1'b1, ~ld, addr[31:2], be}) begin
          n_err++;
          $display("FAIL access_ctrl k=%0d: got req=%b busy=%b we=%b addr=%h be=%b exp we=%b addr=%h be=%b",
                   k, mem_if.MEM_REQ, BUSYWAIT, mem_if.MEM_WE, mem_if.MEM_ADDR,
                   mem_if.MEM_BYTE_EN, ~ld, addr[31:2], be);
        end
        if (!ld) begin
          n_vec++;
          if (mem_if.MEM_WDATA !== wexp) begin
            n_err++;
            $display("FAIL store_wdata: got %h exp %h", mem_if.MEM_WDATA, wexp);
          end
        end
        if (BUSYWAIT === 1'b1) busy_n++;
        if (k == ack_dly) begin
          mem_if.MEM_ACK = 1'b1;
          mem_if.MEM_RDATA = rdata;
          acked = 1;
          if (ld) exp_q.push_back(model_load(f3, addr[1:0], rdata));
          break;
        end
      end
    end

    @(negedge CLK);
    mem_if.MEM_ACK = 1'b0;
    mem_if.MEM_RDATA = $urandom;
    if (code != 2'b00) exp_code = code;
    else if (acked) exp_code = 2'b00;
    else exp_code = 2'b11;
    if (code != 2'b00) exp_busy = 1;
    else if (acked) exp_busy = 2 + ack_dly;
    else exp_busy = 1 + MAXW;
    if (exp_q.size() > 0) exp_rd = exp_q.pop_front();

    n_vec++;
    if ({state_o, FAULT, FAULT_CODE, mem_if.MEM_REQ, BUSYWAIT}
        !== {DONE, (exp_code != 2'b00), exp_code, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL done_status: got st=%0d fault=%b code=%b req=%b busy=%b exp fault=%b code=%b",
               state_o, FAULT, FAULT_CODE, mem_if.MEM_REQ, BUSYWAIT,
               (exp_code != 2'b00), exp_code);
    end
    n_vec++;
    if (READ_DATA !== exp_rd) begin
      n_err++;
      $display("FAIL read_data: got %h exp %h", READ_DATA, exp_rd);
    end
    n_vec++;
    if (busy_n !== exp_busy) begin
      n_err++;
      $display("FAIL busy_cycles: got %0d exp %0d", busy_n, exp_busy);
    end

    if (nx_valid) begin
      MEM_READ = nx_rd; MEM_WRITE = nx_wr; FUNC3 = nx_f3; ADDRESS = nx_addr; WRITE_DATA = nx_wd;
      nx_valid = 0;
      #1;
      n_vec++;
      if (BUSYWAIT !== 1'b0) begin
        n_err++;
        $display("FAIL done_busy_with_strobe: got %b exp 0", BUSYWAIT);
      end
    end else begin
      idle_inputs();
    end

    @(negedge CLK);
    n_vec++;
    if ({state_o, FAULT, FAULT_CODE, mem_if.MEM_REQ} !== {IDLE, 1'b0, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL back_to_idle: got st=%0d fault=%b code=%b req=%b exp st=0 0 00 0",
               state_o, FAULT, FAULT_CODE, mem_if.MEM_REQ);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++;
    if ({READ_DATA, FAULT, FAULT_CODE, mem_if.MEM_REQ, mem_if.MEM_WE, mem_if.MEM_ADDR,
         mem_if.MEM_BYTE_EN, mem_if.MEM_WDATA, state_o, BUSYWAIT} !== '0) begin
      n_err++;
      $display("FAIL reset_values: rd=%h f=%b c=%b req=%b we=%b addr=%h be=%b wd=%h st=%0d busy=%b exp all zero",
               READ_DATA, FAULT, FAULT_CODE, mem_if.MEM_REQ, mem_if.MEM_WE, mem_if.MEM_ADDR,
               mem_if.MEM_BYTE_EN, mem_if.MEM_WDATA, state_o, BUSYWAIT);
    end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_store();
    do_access(0, 1, F3_W, 32'h1000_0008, 32'hDEAD_BEEF, 0, '0);
    do_access(0, 1, F3_B, 32'h0000_0003, 32'h0000_00A5, 0, '0);
    do_access(0, 1, F3_H, 32'h0000_0102, 32'h1234_5678, 2, '0);
  endtask

  task automatic test_load();
    do_access(1, 0, F3_BU, 32'h0000_0041, '0, 0, 32'h1234_8056);
    do_access(1, 0, F3_B,  32'h0000_0041, '0, 1, 32'h1234_8056);
    do_access(1, 0, F3_H,  32'h0000_0082, '0, 0, 32'h8001_0000);
    do_access(1, 1, F3_W,  32'h0000_0100, 32'hFFFF_FFFF, 3, 32'hCAFE_F00D);
  endtask

  task automatic test_fault();
    do_access(1, 0, F3_W,  32'h0000_0002, '0, 0, 32'h1111_1111);
    do_access(1, 0, 3'b011, 32'h0000_0000, '0, 0, 32'h2222_2222);
    do_access(1, 0, 3'b011, 32'h0000_0001, '0, 0, 32'h3333_3333);
    do_access(0, 1, F3_BU, 32'h0000_0000, 32'h55, 0, '0);
  endtask

  task automatic test_timeout();
    do_access(1, 0, F3_W, 32'h0000_0200, '0, -1, 32'h9999_9999);
  endtask

  task automatic test_reset_mid_access();
    MEM_READ = 1; FUNC3 = F3_W; ADDRESS = 32'h0000_0300;
    @(negedge CLK);
    n_vec++;
    if (mem_if.MEM_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_req: got %b exp 1", mem_if.MEM_REQ);
    end
    #2;
    RESET = 1'b0;
    idle_inputs();
    #1;
    exp_rd = '0;
    n_vec++;
    if ({mem_if.MEM_REQ, BUSYWAIT, state_o, READ_DATA} !== {1'b0, 1'b0, IDLE, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got req=%b busy=%b st=%0d rd=%h exp 0 0 0 0",
               mem_if.MEM_REQ, BUSYWAIT, state_o, READ_DATA);
    end
    @(negedge CLK);
    RESET = 1'b1;
    mem_if.MEM_ACK = 1'b1;
    mem_if.MEM_RDATA = 32'hBAD0_BAD0;
    @(negedge CLK);
    mem_if.MEM_ACK = 1'b0;
    n_vec++;
    if ({state_o, READ_DATA, mem_if.MEM_REQ} !== {IDLE, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL late_ack: got st=%0d rd=%h req=%b exp 0 0 0", state_o, READ_DATA, mem_if.MEM_REQ);
    end
    do_access(1, 0, F3_HU, 32'h0000_0302, '0, 1, 32'hFEDC_BA98);
  endtask

  task automatic test_back_to_back();
    nx_valid = 1; nx_rd = 1; nx_wr = 0; nx_f3 = F3_B; nx_addr = 32'h0000_0403; nx_wd = '0;
    do_access(0, 1, F3_W, 32'h0000_0400, 32'h0BAD_CAFE, 0, '0);
    do_access(1, 0, F3_B, 32'h0000_0403, '0, 0, 32'h80AA_BBCC);
  endtask

  task automatic test_random();
    int          r;
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(1, 3);
      rd   = r[0];
      wr   = r[1];
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'($urandom_range(0, 3)) & (f3[1] ? 2'b00 : f3[0] ? 2'b10 : 2'b11);
      do_access(rd, wr, f3, addr, $urandom, $urandom_range(0, 5) - 1, $urandom);
    end
  endtask

  initial begin
    idle_inputs();
    mem_if.MEM_ACK = 1'b0;
    mem_if.MEM_RDATA = '0;
    repeat (3) @(negedge CLK);
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
